gb_instr_sequencer: RTL and testbench

- Instruction issuer that drives the processor's instruction/valid input and reads back its probe output.
- Holds a small writable program memory and replays it as a paced valid stream, with a programmable gap and repeat count.
- Captures the processor probe after the last instruction and signals done.
- Sits between the testbench/host side and the processor core; the top level connects instruction, valid and probe_in directly to the core.

---
 rtl/gb_instr_sequencer_pkg.sv | 16 +
 rtl/gb_instr_sequencer_if.sv | 32 +++
 rtl/gb_instr_sequencer_prog_mem.sv | 34 +++
 rtl/gb_instr_sequencer.sv | 155 +++++++++++++++
 tb/tb_gb_instr_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/gb_instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer slice.
// The FSM encoding lives here so the debug port and the bench agree on it.
package gb_seq_pkg;

   localparam int         DEFAULT_DEPTH = 16;
   localparam logic [7:0] NOP_INSTR     = 8'h00;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      GAP     = 3'd2,
      CAPTURE = 3'd3,
      FINISH  = 3'd4
   } seq_state_t;

endpackage

// File: rtl/gb_instr_sequencer_if.sv
// Host/core-facing signal bundle of the sequencer.
// start is a request sampled only while idle; busy/done report progress; valid
// qualifies instruction for exactly one cycle and the core has no backpressure.
interface gb_seq_if #(
   parameter int ADDR_W = 4,
   parameter int GAP_W  = 4
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic [ADDR_W:0]   prog_len;
   logic [GAP_W-1:0]  gap;
   logic [7:0]        repeat_cnt;
   logic              start;
   logic              busy;
   logic              done;
   logic [7:0]        instruction;
   logic              valid;
   logic [15:0]       probe_in;
   logic [15:0]       result;
   logic [15:0]       issued_count;

   modport master (
      output wr_en, wr_addr, wr_data, prog_len, gap, repeat_cnt, start, probe_in,
      input  busy, done, instruction, valid, result, issued_count
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, prog_len, gap, repeat_cnt, start, probe_in,
      output busy, done, instruction, valid, result, issued_count
   );
endinterface

// File: rtl/gb_instr_sequencer_prog_mem.sv
// Program memory: DEPTH x 8 register file, synchronous write and clear,
// combinational read.
module gb_prog_mem #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/gb_instr_sequencer.sv
// Replays the program memory to the core as a paced valid stream and captures
// the core probe once the final instruction has been absorbed.
module gb_instr_sequencer
   import gb_seq_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = 4,
   parameter int GAP_W  = 4
) (
   input  logic       clock,
   input  logic       reset,
   gb_seq_if.slave    bus,
   output seq_state_t dbg_state
);

   localparam logic [2:0] ST_IDLE    = IDLE;
   localparam logic [2:0] ST_ISSUE   = ISSUE;
   localparam logic [2:0] ST_GAP     = GAP;
   localparam logic [2:0] ST_CAPTURE = CAPTURE;
   localparam logic [2:0] ST_FINISH  = FINISH;

   localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

   logic [2:0]        state_q,   state_d;
   logic [ADDR_W-1:0] ptr_q,     ptr_d;
   logic [ADDR_W:0]   len_q,     len_d;
   logic [GAP_W-1:0]  gap_q,     gap_d;
   logic [GAP_W-1:0]  gcnt_q,    gcnt_d;
   logic [7:0]        passes_q,  passes_d;
   logic              skip_q,    skip_d;
   logic [15:0]       issued_q,  issued_d;
   logic [15:0]       result_q,  result_d;
   logic              valid_q,   valid_d;
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;
   logic [7:0]        instr_q,   instr_d;

   logic [7:0]        mem_rdata;
   logic              last_in_pass;

   gb_prog_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
      .clock (clock),
      .reset (reset),
      .we    (state_q == ST_IDLE && bus.wr_en),
      .waddr (bus.wr_addr),
      .wdata (bus.wr_data),
      .raddr (ptr_d),
      .rdata (mem_rdata)
   );

   assign last_in_pass = ({1'b0, ptr_q} == (len_q - (ADDR_W+1)'(1)));

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      len_d    = len_q;
      gap_d    = gap_q;
      gcnt_d   = gcnt_q;
      passes_d = passes_q;
      skip_d   = skip_q;
      issued_d = issued_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.wr_en) begin
               len_d    = (bus.prog_len > LEN_MAX) ? LEN_MAX : bus.prog_len;
               gap_d    = bus.gap;
               passes_d = (bus.repeat_cnt == 8'd0) ? 8'd1 : bus.repeat_cnt;
               issued_d = 16'd0;
               ptr_d    = '0;
               // An empty program still spends one busy cycle, but must not
               // overwrite result, so it passes through CAPTURE with skip set.
               skip_d   = (bus.prog_len == '0);
               state_d  = (bus.prog_len == '0) ? ST_CAPTURE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            issued_d = (issued_q == 16'hFFFF) ? issued_q : issued_q + 16'd1;
            if (last_in_pass && passes_q == 8'd1) begin
               state_d = ST_CAPTURE;
            end else begin
               if (last_in_pass) begin
                  ptr_d    = '0;
                  passes_d = passes_q - 8'd1;
               end else begin
                  ptr_d = ptr_q + ADDR_W'(1);
               end
               if (gap_q != '0) begin
                  gcnt_d  = gap_q;
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            gcnt_d = gcnt_q - GAP_W'(1);
            if (gcnt_q == GAP_W'(1)) state_d = ST_ISSUE;
         end
         ST_CAPTURE: begin
            if (!skip_q) result_d = bus.probe_in;
            state_d = ST_FINISH;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      valid_d = (state_d == ST_ISSUE);
      busy_d  = (state_d == ST_ISSUE) || (state_d == ST_GAP) || (state_d == ST_CAPTURE);
      done_d  = (state_d == ST_FINISH);
      instr_d = valid_d ? mem_rdata : NOP_INSTR;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         len_q    <= '0;
         gap_q    <= '0;
         gcnt_q   <= '0;
         passes_q <= 8'd0;
         skip_q   <= 1'b0;
         issued_q <= 16'd0;
         result_q <= 16'd0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         instr_q  <= NOP_INSTR;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         len_q    <= len_d;
         gap_q    <= gap_d;
         gcnt_q   <= gcnt_d;
         passes_q <= passes_d;
         skip_q   <= skip_d;
         issued_q <= issued_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         instr_q  <= instr_d;
      end
   end

   assign bus.valid        = valid_q;
   assign bus.instruction  = instr_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.result       = result_q;
   assign bus.issued_count = issued_q;
   assign dbg_state        = seq_state_t'(state_q);

endmodule

// File: tb/tb_gb_instr_sequencer.sv
// Directed bench for gb_instr_sequencer with a tiny core stub on probe_in
// (0x80: A += 1, 0x81: A += 2, anything else leaves A alone).
module tb_gb_instr_sequencer;
   import gb_seq_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       model_clr = 1'b0;
   logic [7:0] reg_a;
   seq_state_t dbg_state;

   gb_seq_if #(.ADDR_W(4), .GAP_W(4)) bus ();

   gb_instr_sequencer #(.DEPTH(16), .ADDR_W(4), .GAP_W(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   always #5 clock = ~clock;

   // Core stub: registers update on the edge that samples valid.
   always @(posedge clock) begin
      if (reset || model_clr) reg_a <= 8'h00;
      else if (bus.valid) begin
         case (bus.instruction)
            8'h80:   reg_a <= reg_a + 8'd1;
            8'h81:   reg_a <= reg_a + 8'd2;
            default: reg_a <= reg_a;
         endcase
      end
   end
   assign bus.probe_in = {reg_a, 8'h00};

   typedef struct {
      logic [4:0]  len;
      logic [3:0]  gap;
      logic [7:0]  rep;
      logic [7:0]  p0, p1;
      logic [39:0] pat;
      int          done_cyc;
      logic [15:0] issued;
      logic [15:0] result;
   } vec_t;

   vec_t       vecs[6];
   logic [7:0] exp_q[$];
   int         n_vec = 0;
   int         n_miss = 0;

   function automatic vec_t mk(logic [4:0] len, logic [3:0] g, logic [7:0] rep,
                               logic [7:0] p0, logic [7:0] p1, logic [39:0] pat,
                               int done_cyc, logic [15:0] issued, logic [15:0] result);
      vec_t v;
      v.len = len; v.gap = g; v.rep = rep; v.p0 = p0; v.p1 = p1; v.pat = pat;
      v.done_cyc = done_cyc; v.issued = issued; v.result = result;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic load_prog(input logic [7:0] p0, input logic [7:0] p1);
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         bus.wr_en = 1'b1; bus.wr_addr = 4'(i); bus.wr_data = (i % 2 == 1) ? p1 : p0;
      end
      @(negedge clock);
      bus.wr_en = 1'b0;
   endtask

   task automatic clear_model();
      @(negedge clock); model_clr = 1'b1;
      @(negedge clock); model_clr = 1'b0;
   endtask

   // Pulses start and watches 40 cycles; cycle k is the one after edge T+k-1.
   task automatic run_observe(input logic [4:0] len, input logic [3:0] g, input logic [7:0] rep,
                              input bit interfere, output logic [39:0] pat,
                              output int done_cyc, output logic busy1, output logic busy_at_done);
      @(negedge clock);
      bus.prog_len = len; bus.gap = g; bus.repeat_cnt = rep; bus.start = 1'b1;
      @(posedge clock); #1;
      bus.start = 1'b0;
      pat = '0; done_cyc = -1; busy1 = 1'b0; busy_at_done = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         if (k == 1) busy1 = bus.busy;
         if (bus.valid) begin
            pat[k-1] = 1'b1;
            if (exp_q.size() == 0) check("extra_valid", 1, 0);
            else check("instr", bus.instruction, exp_q.pop_front());
         end
         if (bus.done && done_cyc < 0) begin
            done_cyc = k;
            busy_at_done = bus.busy;
         end
         if (interfere && (k == 2 || k == 3)) begin
            bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 8'hAA; bus.start = 1'b1;
         end else if (interfere && k == 4) begin
            bus.wr_en = 1'b0; bus.start = 1'b0;
         end
         @(posedge clock); #1;
      end
   endtask

   initial begin
      logic [39:0] pat;
      int          done_cyc, np, nl;
      logic        busy1, busy_at_done, seen;

      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.prog_len = '0;
      bus.gap = '0; bus.repeat_cnt = '0; bus.start = 1'b0;

      vecs[0] = mk(5'd3,  4'd0, 8'd1, 8'h80, 8'h80, 40'h0007, 5,  16'd3,  16'h0300);
      vecs[1] = mk(5'd3,  4'd2, 8'd1, 8'h80, 8'h80, 40'h0049, 9,  16'd3,  16'h0300);
      vecs[2] = mk(5'd2,  4'd0, 8'd3, 8'h80, 8'h81, 40'h003F, 8,  16'd6,  16'h0900);
      vecs[3] = mk(5'd0,  4'd0, 8'd1, 8'h80, 8'h81, 40'h0000, 2,  16'd0,  16'h0900);
      vecs[4] = mk(5'd1,  4'd3, 8'd2, 8'h81, 8'h80, 40'h0011, 7,  16'd2,  16'h0400);
      vecs[5] = mk(5'd20, 4'd0, 8'd0, 8'h80, 8'h80, 40'hFFFF, 18, 16'd16, 16'h1000);

      repeat (3) @(posedge clock);
      #1;
      check("reset_outputs",
            {bus.busy, bus.done, bus.valid, bus.instruction, bus.result, bus.issued_count}, 64'd0);
      reset = 1'b0;

      for (int v = 0; v < 6; v++) begin
         load_prog(vecs[v].p0, vecs[v].p1);
         clear_model();
         np = (vecs[v].rep == 8'd0) ? 1 : int'(vecs[v].rep);
         nl = (vecs[v].len > 5'd16) ? 16 : int'(vecs[v].len);
         for (int p = 0; p < np; p++)
            for (int i = 0; i < nl; i++) exp_q.push_back((i % 2 == 1) ? vecs[v].p1 : vecs[v].p0);
         run_observe(vecs[v].len, vecs[v].gap, vecs[v].rep, 1'b0, pat, done_cyc, busy1, busy_at_done);
         check($sformatf("v%0d_valid_pattern", v), pat, vecs[v].pat);
         check($sformatf("v%0d_done_cycle", v), done_cyc, vecs[v].done_cyc);
         check($sformatf("v%0d_busy_first", v), busy1, 1);
         check($sformatf("v%0d_busy_at_done", v), busy_at_done, 0);
         check($sformatf("v%0d_issued", v), bus.issued_count, vecs[v].issued);
         check($sformatf("v%0d_result", v), bus.result, vecs[v].result);
         check($sformatf("v%0d_missing_valids", v), exp_q.size(), 0);
         exp_q.delete();
      end

      // start and wr_en during a run are ignored; memory is read back by a rerun
      load_prog(8'h80, 8'h81);
      clear_model();
      exp_q.push_back(8'h80); exp_q.push_back(8'h81);
      run_observe(5'd2, 4'd3, 8'd1, 1'b1, pat, done_cyc, busy1, busy_at_done);
      check("busyin_pattern", pat, 40'h0011);
      check("busyin_done_cycle", done_cyc, 7);
      exp_q.delete();
      exp_q.push_back(8'h80); exp_q.push_back(8'h81);
      run_observe(5'd2, 4'd0, 8'd1, 1'b0, pat, done_cyc, busy1, busy_at_done);
      check("readback_pattern", pat, 40'h0003);
      check("readback_missing", exp_q.size(), 0);
      exp_q.delete();

      // start and wr_en together while idle: write wins, no run
      @(negedge clock);
      bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 8'h55;
      bus.prog_len = 5'd1; bus.gap = 4'd0; bus.repeat_cnt = 8'd1; bus.start = 1'b1;
      @(negedge clock);
      bus.wr_en = 1'b0; bus.start = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clock);
         seen = seen | bus.busy | bus.valid | bus.done;
      end
      check("start_wr_no_run", seen, 0);
      exp_q.push_back(8'h55);
      run_observe(5'd1, 4'd0, 8'd1, 1'b0, pat, done_cyc, busy1, busy_at_done);
      check("start_wr_write_applied", pat, 40'h0001);
      check("start_wr_missing", exp_q.size(), 0);
      exp_q.delete();

      // reset during the second valid aborts and clears memory
      load_prog(8'h80, 8'h80);
      @(negedge clock);
      bus.prog_len = 5'd3; bus.gap = 4'd0; bus.repeat_cnt = 8'd1; bus.start = 1'b1;
      @(posedge clock); #1;
      bus.start = 1'b0;
      check("abort_valid1", bus.valid, 1);
      @(posedge clock); #1;
      check("abort_valid2", bus.valid, 1);
      reset = 1'b1;
      @(posedge clock); #1;
      check("abort_outputs", {bus.valid, bus.busy, bus.done}, 0);
      reset = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clock); #1;
         seen = seen | bus.done;
      end
      check("abort_no_done", seen, 0);
      check("abort_result", bus.result, 16'h0000);
      exp_q.push_back(8'h00);
      run_observe(5'd1, 4'd0, 8'd1, 1'b0, pat, done_cyc, busy1, busy_at_done);
      check("abort_mem_cleared_pattern", pat, 40'h0001);
      check("abort_mem_cleared_missing", exp_q.size(), 0);
      check("abort_rerun_issued", bus.issued_count, 16'd1);
      check("abort_rerun_done", done_cyc, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
